// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator program sequencer.
// Instruction word layout: {halt, m, s[3:0], b[3:0]}.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

  localparam int unsigned INSTR_W  = 10;
  localparam int unsigned HALT_BIT = 9;
  localparam int unsigned M_BIT    = 8;
  localparam int unsigned S_MSB    = 7;
  localparam int unsigned S_LSB    = 4;
  localparam int unsigned B_MSB    = 3;
  localparam int unsigned B_LSB    = 0;

  // {m, s}: arithmetic mode, A plus B
  localparam logic [4:0] ALU_ADD = 5'b0_1001;

endpackage

// File: rtl/acc_prog_mem.sv
// DEPTH x 10 register-file instruction store: one synchronous write port and
// two asynchronous read ports (current word and the word after it).
module acc_prog_mem
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o,
  input  logic [AW-1:0]      raddr_nxt_i,
  output logic [INSTR_W-1:0] rdata_nxt_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o     = mem_q[raddr_i];
  assign rdata_nxt_o = mem_q[raddr_nxt_i];

endmodule

// File: rtl/acc_seq_ctrl.sv
// Program sequencer: issues one stored instruction per cycle to an external
// 4-bit ALU and accumulates its result, flagging any carry-out seen in a run.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AW           = 3,
  parameter int unsigned CLR_ON_CARRY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_s,
  output logic               alu_m,
  input  logic [3:0]         alu_y,
  input  logic               alu_cout_n,
  output logic [3:0]         acc_q,
  output logic               carry_flag,
  output logic [AW-1:0]      pc
);

  localparam logic [AW-1:0] LastPc = AW'(DEPTH - 1);

  acc_state_e         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d, pc_nxt;
  logic [3:0]         accum_q, accum_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [INSTR_W-1:0] instr, instr_nxt;
  logic               exec;

  assign pc_nxt = pc_q + AW'(1);

  acc_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk_i       (clk),
    .we_i        (prog_we && (state_q == ST_IDLE)),
    .waddr_i     (prog_addr),
    .wdata_i     (prog_data),
    .raddr_i     (pc_q),
    .rdata_o     (instr),
    .raddr_nxt_i (pc_nxt),
    .rdata_nxt_o (instr_nxt)
  );

  assign exec = (state_q == ST_RUN) && !instr[HALT_BIT];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    accum_d = accum_q;
    carry_d = carry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          accum_d = '0;
          carry_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (instr[HALT_BIT]) begin
          state_d = ST_DONE;
        end else begin
          if (!alu_cout_n) begin
            carry_d = 1'b1;
            accum_d = (CLR_ON_CARRY != 0) ? 4'h0 : alu_y;
          end else begin
            accum_d = alu_y;
          end
          if (pc_q == LastPc) begin
            state_d = ST_DONE;
          end else begin
            pc_d = pc_nxt;
            // Finish now if the next word halts, so busy counts executed ops only.
            if (instr_nxt[HALT_BIT]) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      accum_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      accum_q <= accum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign alu_a      = accum_q;
  assign alu_b      = exec ? instr[B_MSB:B_LSB] : 4'h0;
  assign alu_s      = exec ? instr[S_MSB:S_LSB] : 4'h0;
  assign alu_m      = exec ? instr[M_BIT] : 1'b0;
  assign acc_q      = accum_q;
  assign carry_flag = carry_q;
  assign pc         = pc_q;

endmodule
